// File: rtl/loop_scheduler.sv
// Convolution loop-nest scheduler.
// Walks bb > nn > ii > kky > kkx > xx > yy (yy innermost) and presents one
// iteration per handshake as registered weight/activation/psum addresses,
// together with first/last accumulation markers for the psum buffer.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; configuration checked on the start cycle
// S_RUN  | iterations issued, counters advance on issue_valid&&issue_ready
// S_DONE | one-cycle job end, done pulses here, then back to S_IDLE
module loop_scheduler #(
  parameter int DIM_W   = 16,
  parameter int WEI_AW  = 10,
  parameter int ACT_AW  = 10,
  parameter int PSUM_AW = 10,
  parameter int LANES   = 4
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     stride,
  input  logic [DIM_W-1:0]     fkx,
  input  logic [DIM_W-1:0]     fky,
  input  logic [DIM_W-1:0]     x,
  input  logic [DIM_W-1:0]     y,
  input  logic [DIM_W-1:0]     nc,
  input  logic [DIM_W-1:0]     ic,
  input  logic [DIM_W-1:0]     batch,
  input  logic [DIM_W-1:0]     padding_x,
  input  logic [DIM_W-1:0]     padding_y,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic                 wei_read_en,
  output logic                 act_read_en,
  output logic [WEI_AW-1:0]    wei_read_addr,
  output logic [ACT_AW-1:0]    act_read_addr,
  output logic [PSUM_AW-1:0]   psum_addr,
  output logic                 psum_first,
  output logic                 psum_last
);

  // Padded extents need two extra bits; wrap compares need one more.
  localparam int CW = DIM_W + 2;
  localparam int EW = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state;

  // Captured job configuration (channel counts held in LANES units).
  logic [DIM_W-1:0] stride_q, fkx_q, fky_q, ncl_q, icl_q, batch_q;
  logic [CW-1:0]    xp_q, yp_q, ox_q, oy_q;

  // Loop counters; xpos/ypos track xx*stride and yy*stride.
  logic [DIM_W-1:0] bb, nnl, iil, kky, kkx, xx, yy;
  logic [CW-1:0]    xpos, ypos;

  // Start-cycle view of the raw inputs.
  logic [CW-1:0]    xp_in, yp_in, ox_in, oy_in;
  logic [DIM_W-1:0] stride_nz, ncl_in, icl_in;
  logic             cfg_legal;

  // Legality check and derived extents from the live inputs.
  always_comb begin
    xp_in     = CW'(x) + (CW'(padding_x) << 1);
    yp_in     = CW'(y) + (CW'(padding_y) << 1);
    ncl_in    = nc / DIM_W'(LANES);
    icl_in    = ic / DIM_W'(LANES);
    stride_nz = (stride == '0) ? DIM_W'(1) : stride;
    cfg_legal = (stride != '0) && (fkx != '0) && (fky != '0) &&
                (x != '0) && (y != '0) && (nc != '0) && (ic != '0) &&
                (batch != '0) &&
                (xp_in >= CW'(fkx)) && (yp_in >= CW'(fky)) &&
                ((nc % DIM_W'(LANES)) == '0) && ((ic % DIM_W'(LANES)) == '0);
    ox_in     = ((xp_in - CW'(fkx)) / CW'(stride_nz)) + 1'b1;
    oy_in     = ((yp_in - CW'(fky)) / CW'(stride_nz)) + 1'b1;
  end

  logic wrap_y, wrap_x, wrap_kx, wrap_ky, wrap_i, wrap_n, wrap_b, last_iter;
  logic [DIM_W-1:0] n_bb, n_nnl, n_iil, n_kky, n_kkx, n_xx, n_yy;
  logic [CW-1:0]    n_xpos, n_ypos;

  // Odometer step to the next iteration; xx/yy wrap on position overrun.
  always_comb begin
    wrap_y  = (EW'(ypos) + EW'(stride_q) + EW'(fky_q)) > EW'(yp_q);
    wrap_x  = (EW'(xpos) + EW'(stride_q) + EW'(fkx_q)) > EW'(xp_q);
    wrap_kx = (kkx == fkx_q - 1'b1);
    wrap_ky = (kky == fky_q - 1'b1);
    wrap_i  = (iil == icl_q - 1'b1);
    wrap_n  = (nnl == ncl_q - 1'b1);
    wrap_b  = (bb == batch_q - 1'b1);
    last_iter = wrap_y && wrap_x && wrap_kx && wrap_ky && wrap_i && wrap_n && wrap_b;

    n_bb = bb;  n_nnl = nnl; n_iil = iil; n_kky = kky; n_kkx = kkx;
    n_xx = xx;  n_yy = yy;   n_xpos = xpos; n_ypos = ypos;
    if (!wrap_y) begin
      n_yy   = yy + 1'b1;
      n_ypos = ypos + CW'(stride_q);
    end else begin
      n_yy   = '0;
      n_ypos = '0;
      if (!wrap_x) begin
        n_xx   = xx + 1'b1;
        n_xpos = xpos + CW'(stride_q);
      end else begin
        n_xx   = '0;
        n_xpos = '0;
        if (!wrap_kx) n_kkx = kkx + 1'b1;
        else begin
          n_kkx = '0;
          if (!wrap_ky) n_kky = kky + 1'b1;
          else begin
            n_kky = '0;
            if (!wrap_i) n_iil = iil + 1'b1;
            else begin
              n_iil = '0;
              if (!wrap_n) n_nnl = nnl + 1'b1;
              else begin
                n_nnl = '0;
                n_bb  = bb + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  logic [WEI_AW-1:0]  a_wei;
  logic [ACT_AW-1:0]  a_act;
  logic [PSUM_AW-1:0] a_psum;
  logic               a_first, a_last;

  // Addresses of the next iteration. Products are taken modulo the port
  // width, which yields the same bits as a full-width result truncated.
  always_comb begin
    a_wei  = ((WEI_AW'(n_nnl) * WEI_AW'(icl_q) + WEI_AW'(n_iil)) * WEI_AW'(fky_q)
              + WEI_AW'(n_kky)) * WEI_AW'(fkx_q) + WEI_AW'(n_kkx);
    a_act  = ((ACT_AW'(n_bb) * ACT_AW'(icl_q) + ACT_AW'(n_iil)) * ACT_AW'(yp_q)
              + ACT_AW'(n_ypos) + ACT_AW'(n_kky)) * ACT_AW'(xp_q)
              + ACT_AW'(n_xpos) + ACT_AW'(n_kkx);
    a_psum = ((PSUM_AW'(n_bb) * PSUM_AW'(ncl_q) + PSUM_AW'(n_nnl)) * PSUM_AW'(oy_q)
              + PSUM_AW'(n_yy)) * PSUM_AW'(ox_q) + PSUM_AW'(n_xx);
    a_first = (n_iil == '0) && (n_kky == '0) && (n_kkx == '0);
    a_last  = (n_iil == icl_q - 1'b1) && (n_kky == fky_q - 1'b1) &&
              (n_kkx == fkx_q - 1'b1);
  end

  assign wei_read_en = issue_valid;
  assign act_read_en = issue_valid;

  // Control FSM with registered status and issue outputs.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; issue_valid <= 1'b0;
      wei_read_addr <= '0; act_read_addr <= '0; psum_addr <= '0;
      psum_first <= 1'b0; psum_last <= 1'b0;
      stride_q <= '0; fkx_q <= '0; fky_q <= '0; ncl_q <= '0; icl_q <= '0;
      batch_q <= '0; xp_q <= '0; yp_q <= '0; ox_q <= '0; oy_q <= '0;
      bb <= '0; nnl <= '0; iil <= '0; kky <= '0; kkx <= '0; xx <= '0; yy <= '0;
      xpos <= '0; ypos <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            stride_q <= stride; fkx_q <= fkx; fky_q <= fky;
            ncl_q <= ncl_in; icl_q <= icl_in; batch_q <= batch;
            xp_q <= xp_in; yp_q <= yp_in; ox_q <= ox_in; oy_q <= oy_in;
            bb <= '0; nnl <= '0; iil <= '0; kky <= '0; kkx <= '0;
            xx <= '0; yy <= '0; xpos <= '0; ypos <= '0;
            if (cfg_legal) begin
              state <= S_RUN;
              busy <= 1'b1; err <= 1'b0; issue_valid <= 1'b1;
              wei_read_addr <= '0; act_read_addr <= '0; psum_addr <= '0;
              psum_first <= 1'b1;
              psum_last  <= (icl_in == DIM_W'(1)) && (fky == DIM_W'(1)) &&
                            (fkx == DIM_W'(1));
            end else begin
              state <= S_DONE;
              err <= 1'b1; done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue_valid && issue_ready) begin
            if (last_iter) begin
              state <= S_DONE;
              issue_valid <= 1'b0; busy <= 1'b0; done <= 1'b1;
            end else begin
              bb <= n_bb; nnl <= n_nnl; iil <= n_iil; kky <= n_kky; kkx <= n_kkx;
              xx <= n_xx; yy <= n_yy; xpos <= n_xpos; ypos <= n_ypos;
              wei_read_addr <= a_wei; act_read_addr <= a_act; psum_addr <= a_psum;
              psum_first <= a_first; psum_last <= a_last;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_scheduler.sv
// Self-checking bench for loop_scheduler: directed and random jobs against
// a nested-loop reference model of the iteration sequence.
module tb_loop_scheduler;
  localparam int DIM_W = 16, WEI_AW = 10, ACT_AW = 10, PSUM_AW = 10, LANES = 4;

  logic core_clk = 1'b0, rst = 1'b1, start = 1'b0, issue_ready = 1'b0;
  logic [DIM_W-1:0] stride = '0, fkx = '0, fky = '0, x = '0, y = '0;
  logic [DIM_W-1:0] nc = '0, ic = '0, batch = '0, padding_x = '0, padding_y = '0;
  logic busy, done, err, issue_valid, wei_read_en, act_read_en, psum_first, psum_last;
  logic [WEI_AW-1:0] wei_read_addr;
  logic [ACT_AW-1:0] act_read_addr;
  logic [PSUM_AW-1:0] psum_addr;

  loop_scheduler #(.DIM_W(DIM_W), .WEI_AW(WEI_AW), .ACT_AW(ACT_AW),
                   .PSUM_AW(PSUM_AW), .LANES(LANES)) dut (
    .core_clk(core_clk), .rst(rst), .start(start), .stride(stride),
    .fkx(fkx), .fky(fky), .x(x), .y(y), .nc(nc), .ic(ic), .batch(batch),
    .padding_x(padding_x), .padding_y(padding_y), .busy(busy), .done(done),
    .err(err), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .wei_read_en(wei_read_en), .act_read_en(act_read_en),
    .wei_read_addr(wei_read_addr), .act_read_addr(act_read_addr),
    .psum_addr(psum_addr), .psum_first(psum_first), .psum_last(psum_last));

  always #5 core_clk = ~core_clk;

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_obs();
    return {wei_read_addr, act_read_addr, psum_addr, psum_first, psum_last};
  endfunction

  function automatic logic [63:0] all_outs();
    return {26'd0, busy, done, err, issue_valid, wei_read_en, act_read_en,
            wei_read_addr, act_read_addr, psum_addr, psum_first, psum_last};
  endfunction

  // Reference: plain nested loops straight from the address formulas.
  task automatic build_model(input int st, fx, fy, xi, yi, nci, ici, bt, px, py);
    int xp, yp, ox, oy, w, a, p;
    logic [9:0] w10, a10, p10;
    logic f, l;
    exp_q.delete();
    xp = xi + 2 * px;
    yp = yi + 2 * py;
    ox = (xp - fx) / st + 1;
    oy = (yp - fy) / st + 1;
    for (int bb = 0; bb < bt; bb++)
      for (int nn = 0; nn < nci; nn += LANES)
        for (int ii = 0; ii < ici; ii += LANES)
          for (int ky = 0; ky < fy; ky++)
            for (int kx = 0; kx < fx; kx++)
              for (int ix = 0; ix < ox; ix++)
                for (int iy = 0; iy < oy; iy++) begin
                  w = (((nn / LANES) * (ici / LANES) + ii / LANES) * fy + ky) * fx + kx;
                  a = (((bb * (ici / LANES) + ii / LANES) * yp) + iy * st + ky) * xp + ix * st + kx;
                  p = ((bb * (nci / LANES) + nn / LANES) * oy + iy) * ox + ix;
                  f = (ii == 0) && (ky == 0) && (kx == 0);
                  l = (ii == ici - LANES) && (ky == fy - 1) && (kx == fx - 1);
                  w10 = 10'(w); a10 = 10'(a); p10 = 10'(p);
                  exp_q.push_back({w10, a10, p10, f, l});
                end
  endtask

  task automatic drive_cfg(input int st, fx, fy, xi, yi, nci, ici, bt, px, py);
    stride = 16'(st); fkx = 16'(fx); fky = 16'(fy); x = 16'(xi); y = 16'(yi);
    nc = 16'(nci); ic = 16'(ici); batch = 16'(bt); padding_x = 16'(px); padding_y = 16'(py);
  endtask

  // Runs one job; stall_at>=0 drops ready for 3 cycles at that beat,
  // abort_at>=0 pulses reset when that beat is presented.
  task automatic run_job(input int st, fx, fy, xi, yi, nci, ici, bt, px, py,
                         input bit rand_bp, input int stall_at, input int abort_at,
                         input bit poke, output int beats);
    int nexp, cycles, stalls, stall_left, limit;
    bit done_seen, stalled_once, poked, rdy;
    build_model(st, fx, fy, xi, yi, nci, ici, bt, px, py);
    nexp = exp_q.size();
    limit = nexp * 5 + 50;
    beats = 0; stalls = 0; stall_left = 0; done_seen = 0; stalled_once = 0; poked = 0;
    @(negedge core_clk);
    drive_cfg(st, fx, fy, xi, yi, nci, ici, bt, px, py);
    start = 1'b1;
    issue_ready = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    cycles = 1;
    chk("err_clear", err, 1'b0);
    while (cycles < limit) begin
      if (done) begin
        done_seen = 1;
        break;
      end
      if (abort_at >= 0 && beats == abort_at) begin
        rst = 1'b1;
        #1;
        chk("async_rst_outs", all_outs(), 64'd0);
        @(negedge core_clk);
        chk("rst_hold_outs", all_outs(), 64'd0);
        rst = 1'b0;
        issue_ready = 1'b1;
        repeat (3) @(negedge core_clk);
        chk("idle_after_rst", {busy, issue_valid, done}, 3'b000);
        return;
      end
      chk("valid", issue_valid, 1'b1);
      chk("busy", busy, 1'b1);
      chk("rd_en", {wei_read_en, act_read_en}, 2'b11);
      if (beats >= nexp) begin
        chk("beat_overrun", beats, nexp - 1);
        break;
      end
      chk($sformatf("beat%0d", beats), beat_obs(), exp_q[beats]);
      if (stall_at >= 0 && beats == stall_at && !stalled_once) begin
        stall_left = 3;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        rdy = 0;
        stall_left--;
      end else if (rand_bp) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1;
      if (!rdy) stalls++;
      issue_ready = rdy;
      if (rdy) beats++;
      if (poke && beats == 5 && !poked) begin
        poked = 1;
        start = 1'b1;
        drive_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 9), $urandom_range(0, 9), 4, 6, 3, 1, 2);
      end else start = 1'b0;
      @(negedge core_clk);
      cycles++;
    end
    start = 1'b0;
    chk("done_timeout", done_seen, 1'b1);
    chk("beat_count", beats, nexp);
    chk("done_cycle", cycles, nexp + 1 + stalls);
    chk("end_status", {busy, issue_valid, err}, 3'b000);
    @(negedge core_clk);
    chk("done_one_cycle", {done, busy, issue_valid}, 3'b000);
  endtask

  task automatic run_illegal(input int fx, input int ici);
    @(negedge core_clk);
    drive_cfg(1, fx, 2, 8, 8, 8, ici, 1, 0, 0);
    start = 1'b1;
    issue_ready = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    chk("illegal_done", {done, err, busy, issue_valid}, 4'b1100);
    @(negedge core_clk);
    chk("illegal_after", {done, err, busy, issue_valid}, 4'b0100);
  endtask

  initial begin
    int b;
    int st, fx, fy, xi, yi, px, py;
    repeat (3) @(negedge core_clk);
    chk("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    issue_ready = 1'b1;
    repeat (2) @(negedge core_clk);
    chk("idle_ignores_ready", {busy, issue_valid, done}, 3'b000);

    run_job(1, 2, 2, 8, 8, 8, 8, 1, 0, 0, 0, -1, -1, 0, b);
    chk("base_784", b, 784);
    run_job(1, 2, 2, 8, 8, 8, 8, 1, 0, 0, 0, 10, -1, 0, b);
    chk("bp_784", b, 784);
    run_job(2, 3, 3, 8, 8, 4, 4, 1, 1, 1, 0, -1, -1, 0, b);
    chk("stride_pad_144", b, 144);

    run_illegal(0, 8);
    run_illegal(2, 6);
    run_job(1, 1, 1, 2, 3, 4, 4, 2, 0, 0, 1, -1, -1, 0, b);

    run_job(1, 2, 2, 8, 8, 8, 8, 1, 0, 0, 0, -1, 100, 0, b);
    run_job(1, 2, 2, 8, 8, 8, 8, 1, 0, 0, 0, -1, -1, 0, b);
    chk("restart_784", b, 784);

    for (int j = 0; j < 6; j++) begin
      st = $urandom_range(1, 3);
      fx = $urandom_range(1, 3);
      fy = $urandom_range(1, 3);
      xi = $urandom_range(1, 6);
      yi = $urandom_range(1, 6);
      px = $urandom_range(0, 1);
      py = $urandom_range(0, 1);
      if (xi + 2 * px < fx) xi = fx;
      if (yi + 2 * py < fy) yi = fy;
      run_job(st, fx, fy, xi, yi, 4 * $urandom_range(1, 2), 4 * $urandom_range(1, 2),
              $urandom_range(1, 2), px, py, 1, -1, -1, 1, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
